// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter: round-robin, packet-locked injection arbiter with per-VC credits.
// Define INJECT_STATS_EN to add per-requester flit counters and a stall counter.
module noc_inject_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int DEST_W    = 4,
    parameter int VC_W      = 1,
    parameter int NUM_VCS   = 2,
    parameter int BUF_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]          req_data,
    input  logic [NUM_REQ*DEST_W-1:0]          req_dest,
    input  logic [NUM_REQ*VC_W-1:0]            req_vc,
    input  logic [NUM_REQ-1:0]                 req_tail,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [2+DATA_W+DEST_W+VC_W-1:0]    flit_out,
    output logic                               sendFlit,
    input  logic [VC_W:0]                      credit_in,
    output logic                               en_receiveCredit,
    output logic                               credit_err
`ifdef INJECT_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]              stat_flits,
    output logic [15:0]                        stat_stall
`endif
);

    localparam int CW  = $clog2(BUF_DEPTH + 1);
    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NVC = 2 ** VC_W;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state;
    logic [IW-1:0]     owner;
    logic [IW-1:0]     rrPtr;
    logic [DEST_W-1:0] lockDest;
    logic [VC_W-1:0]   lockVc;
    logic [CW-1:0]     credit [NUM_VCS];

    logic [DATA_W-1:0] reqData [NUM_REQ];
    logic [DEST_W-1:0] reqDest [NUM_REQ];
    logic [VC_W-1:0]   reqVc   [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : gUnpack
        assign reqData[g] = req_data[g*DATA_W +: DATA_W];
        assign reqDest[g] = req_dest[g*DEST_W +: DEST_W];
        assign reqVc[g]   = req_vc[g*VC_W +: VC_W];
    end

    // A VC index outside NUM_VCS never has credit.
    logic [NVC-1:0] vcOk;
    for (genvar v = 0; v < NVC; v++) begin : gVcOk
        if (v < NUM_VCS) begin : gLive
            assign vcOk[v] = credit[v] != '0;
        end else begin : gDead
            assign vcOk[v] = 1'b0;
        end
    end

    logic          grantHit;
    logic [IW-1:0] grantIdx;
    logic [IW-1:0] scan;

    always_comb begin
        grantHit = 1'b0;
        grantIdx = '0;
        scan     = '0;
        unique case (state)
            IDLE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    scan = IW'((int'(rrPtr) + i) % NUM_REQ);
                    if (!grantHit && req_valid[scan] && vcOk[reqVc[scan]]) begin
                        grantHit = 1'b1;
                        grantIdx = scan;
                    end
                end
            end
            LOCKED: begin
                grantHit = vcOk[lockVc];
                grantIdx = owner;
            end
            default: ;
        endcase
    end

    logic              grantOk;
    logic              fire;
    logic              headFlit;
    logic              outTail;
    logic [DEST_W-1:0] outDest;
    logic [VC_W-1:0]   outVc;
    logic [DATA_W-1:0] outData;

    assign grantOk   = grantHit && !rst;
    assign fire      = grantOk && req_valid[grantIdx];
    assign req_ready = grantOk ? (NUM_REQ'(1) << grantIdx) : '0;
    assign headFlit  = (state == IDLE);
    assign outTail   = req_tail[grantIdx];
    assign outDest   = headFlit ? reqDest[grantIdx] : lockDest;
    assign outVc     = headFlit ? reqVc[grantIdx] : lockVc;
    assign outData   = reqData[grantIdx];

    assign en_receiveCredit = !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rrPtr    <= '0;
            lockDest <= '0;
            lockVc   <= '0;
            flit_out <= '0;
            sendFlit <= 1'b0;
        end else begin
            sendFlit <= fire;
            flit_out <= fire ? {1'b1, outTail, outDest, outVc, outData} : '0;
            if (fire) begin
                unique case (state)
                    IDLE: begin
                        rrPtr <= (grantIdx == IW'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
                        if (!outTail) begin
                            state    <= LOCKED;
                            owner    <= grantIdx;
                            lockDest <= outDest;
                            lockVc   <= outVc;
                        end
                    end
                    LOCKED: begin
                        if (outTail) state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    logic            crValid;
    logic [VC_W-1:0] crVc;
    logic [NUM_VCS-1:0] inc;
    logic [NUM_VCS-1:0] dec;

    assign crValid = credit_in[VC_W];
    assign crVc    = credit_in[VC_W-1:0];

    for (genvar v = 0; v < NUM_VCS; v++) begin : gCredEv
        assign inc[v] = crValid && (crVc == VC_W'(v));
        assign dec[v] = fire && (outVc == VC_W'(v));
    end

    // A return with no matching send while full means the network over-credited us.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VCS; v++) credit[v] <= CW'(BUF_DEPTH);
            credit_err <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (inc[v] && !dec[v]) begin
                    if (credit[v] == CW'(BUF_DEPTH)) credit_err <= 1'b1;
                    else credit[v] <= credit[v] + 1'b1;
                end else if (dec[v] && !inc[v]) begin
                    credit[v] <= credit[v] - 1'b1;
                end
            end
        end
    end

`ifdef INJECT_STATS_EN
    logic [15:0] statFlits [NUM_REQ];
    logic [15:0] statStall;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) statFlits[i] <= '0;
            statStall <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fire && grantIdx == IW'(i) && statFlits[i] != 16'hFFFF)
                    statFlits[i] <= statFlits[i] + 16'd1;
            end
            if (|req_valid && !fire && statStall != 16'hFFFF)
                statStall <= statStall + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : gStat
        assign stat_flits[g*16 +: 16] = statFlits[g];
    end
    assign stat_stall = statStall;
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// tb_noc_inject_arbiter: directed stimulus with a flit scoreboard.
// Requester queues drive the inputs; a negedge monitor checks every sent flit.
module tb_noc_inject_arbiter;

    localparam int NR = 4;
    localparam int FW = 39;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [127:0]  req_data;
    logic [15:0]   req_dest;
    logic [NR-1:0] req_vc;
    logic [NR-1:0] req_tail;
    logic [NR-1:0] req_ready;
    logic [FW-1:0] flit_out;
    logic          sendFlit;
    logic [1:0]    credit_in;
    logic          en_receiveCredit;
    logic          credit_err;
`ifdef INJECT_STATS_EN
    logic [NR*16-1:0] stat_flits;
    logic [15:0]      stat_stall;
`endif

    always #5 clk = ~clk;

    noc_inject_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_dest         (req_dest),
        .req_vc           (req_vc),
        .req_tail         (req_tail),
        .req_ready        (req_ready),
        .flit_out         (flit_out),
        .sendFlit         (sendFlit),
        .credit_in        (credit_in),
        .en_receiveCredit (en_receiveCredit),
        .credit_err       (credit_err)
`ifdef INJECT_STATS_EN
        ,
        .stat_flits       (stat_flits),
        .stat_stall       (stat_stall)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    logic [37:0]   rq [NR][$];
    logic [FW-1:0] expQ [$];
    logic          autoCredit = 1'b0;
    logic [NR-1:0] fire;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] st(input logic tail, input logic vc,
                                       input logic [3:0] dest, input logic [31:0] data);
        return {tail, vc, dest, data};
    endfunction

    function automatic logic [FW-1:0] ex(input logic tail, input logic vc,
                                         input logic [3:0] dest, input logic [31:0] data);
        return {1'b1, tail, dest, vc, data};
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i] = 1'b1;
                {req_tail[i], req_vc[i], req_dest[i*4 +: 4], req_data[i*32 +: 32]} = rq[i][0];
            end else begin
                req_valid[i] = 1'b0;
                {req_tail[i], req_vc[i], req_dest[i*4 +: 4], req_data[i*32 +: 32]} = '0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        fire = req_valid & req_ready;
        if (autoCredit && sendFlit) credit_in = {1'b1, flit_out[32]};
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (fire[i]) void'(rq[i].pop_front());
        credit_in = '0;
        drive();
    endtask

    function automatic logic busy();
        logic b;
        b = expQ.size() != 0;
        for (int i = 0; i < NR; i++) if (rq[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic run(input string name, input int maxCyc);
        int n;
        n = 0;
        while (busy() && n < maxCyc) begin
            tick();
            n++;
        end
        chk({name, " drained"}, 64'(busy()), 0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) rq[i].delete();
        drive();
        tick();
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sendFlit) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL extra_flit: got %0h required none", flit_out);
            end else begin
                chk("flit", flit_out, expQ.pop_front());
            end
        end else begin
            chk("idle flit_out", flit_out, 0);
        end
        if (req_ready != '0) chk("ready onehot", 64'($countones(req_ready)), 1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        credit_in = '0;
        fire = '0;
        drive();
        tick();
        tick();
        #3;
        chk("rst sendFlit", 64'(sendFlit), 0);
        chk("rst en_receiveCredit", 64'(en_receiveCredit), 0);
        chk("rst credit_err", 64'(credit_err), 0);
        rq[0].push_back(st(1'b1, 1'b0, 4'h1, 32'h1));
        drive();
        #1;
        chk("rst req_ready", 64'(req_ready), 0);
        rq[0].delete();
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        chk("post-rst en_receiveCredit", 64'(en_receiveCredit), 1);
        chk("post-rst sendFlit", 64'(sendFlit), 0);
        tick();
        #3;
        chk("idle en_receiveCredit", 64'(en_receiveCredit), 1);

        // two 3-flit packets on VC0, body dest/vc inputs deliberately wrong
        autoCredit = 1'b1;
        rq[0].push_back(st(1'b0, 1'b0, 4'h5, 32'hA000_0000));
        rq[0].push_back(st(1'b0, 1'b1, 4'h9, 32'hA000_0001));
        rq[0].push_back(st(1'b1, 1'b1, 4'h9, 32'hA000_0002));
        rq[2].push_back(st(1'b0, 1'b0, 4'h7, 32'hB000_0000));
        rq[2].push_back(st(1'b0, 1'b0, 4'h2, 32'hB000_0001));
        rq[2].push_back(st(1'b1, 1'b0, 4'h2, 32'hB000_0002));
        expQ.push_back(ex(1'b0, 1'b0, 4'h5, 32'hA000_0000));
        expQ.push_back(ex(1'b0, 1'b0, 4'h5, 32'hA000_0001));
        expQ.push_back(ex(1'b1, 1'b0, 4'h5, 32'hA000_0002));
        expQ.push_back(ex(1'b0, 1'b0, 4'h7, 32'hB000_0000));
        expQ.push_back(ex(1'b0, 1'b0, 4'h7, 32'hB000_0001));
        expQ.push_back(ex(1'b1, 1'b0, 4'h7, 32'hB000_0002));
        drive();
        run("packet lock", 40);
        #3;
        chk("lock credit_err", 64'(credit_err), 0);

        // single-flit round robin with wrap
        doReset();
        rq[0].push_back(st(1'b1, 1'b0, 4'h1, 32'hC000_0000));
        rq[0].push_back(st(1'b1, 1'b0, 4'h1, 32'hC000_0004));
        rq[1].push_back(st(1'b1, 1'b0, 4'h2, 32'hC000_0001));
        rq[2].push_back(st(1'b1, 1'b0, 4'h3, 32'hC000_0002));
        rq[3].push_back(st(1'b1, 1'b0, 4'h4, 32'hC000_0003));
        expQ.push_back(ex(1'b1, 1'b0, 4'h1, 32'hC000_0000));
        expQ.push_back(ex(1'b1, 1'b0, 4'h2, 32'hC000_0001));
        expQ.push_back(ex(1'b1, 1'b0, 4'h3, 32'hC000_0002));
        expQ.push_back(ex(1'b1, 1'b0, 4'h4, 32'hC000_0003));
        expQ.push_back(ex(1'b1, 1'b0, 4'h1, 32'hC000_0004));
        drive();
        run("round robin", 30);
        autoCredit = 1'b0;

        // 5-flit packet on VC1 with no returns: stalls after 4
        doReset();
        rq[1].push_back(st(1'b0, 1'b1, 4'h3, 32'hD000_0000));
        rq[1].push_back(st(1'b0, 1'b0, 4'h8, 32'hD000_0001));
        rq[1].push_back(st(1'b0, 1'b0, 4'h8, 32'hD000_0002));
        rq[1].push_back(st(1'b0, 1'b0, 4'h8, 32'hD000_0003));
        rq[1].push_back(st(1'b1, 1'b0, 4'h8, 32'hD000_0004));
        for (int k = 0; k < 4; k++)
            expQ.push_back(ex(1'b0, 1'b1, 4'h3, 32'hD000_0000 + 32'(k)));
        drive();
        tick();
        rq[0].push_back(st(1'b1, 1'b0, 4'h6, 32'hE000_0000));
        drive();
        repeat (6) tick();
        #3;
        chk("vc1 stall ready", 64'(req_ready), 0);
        chk("vc1 four sent", 64'(expQ.size()), 0);
        chk("vc1 fifth pending", 64'(rq[1].size()), 1);
        expQ.push_back(ex(1'b1, 1'b1, 4'h3, 32'hD000_0004));
        expQ.push_back(ex(1'b1, 1'b0, 4'h6, 32'hE000_0000));
        credit_in = 2'b11;
        tick();
        #3;
        chk("vc1 ready after credit", 64'(req_ready), 64'h2);
        run("vc1 resume", 20);

        // over-credit while full
        doReset();
        #3;
        chk("err clear", 64'(credit_err), 0);
        credit_in = 2'b10;
        tick();
        #3;
        chk("err set", 64'(credit_err), 1);
        for (int k = 0; k < 5; k++)
            rq[3].push_back(st(1'b1, 1'b0, 4'hA, 32'hF000_0000 + 32'(k)));
        for (int k = 0; k < 4; k++)
            expQ.push_back(ex(1'b1, 1'b0, 4'hA, 32'hF000_0000 + 32'(k)));
        drive();
        repeat (8) tick();
        #3;
        chk("saturated ready", 64'(req_ready), 0);
        chk("saturated four sent", 64'(expQ.size()), 0);
        chk("err held", 64'(credit_err), 1);
        doReset();
        #3;
        chk("err cleared by rst", 64'(credit_err), 0);

        // reset in the middle of a packet
        rq[2].push_back(st(1'b1, 1'b0, 4'h1, 32'h6000_0000));
        expQ.push_back(ex(1'b1, 1'b0, 4'h1, 32'h6000_0000));
        drive();
        run("rr advance", 10);
        rq[1].push_back(st(1'b0, 1'b0, 4'h6, 32'h7000_0000));
        rq[1].push_back(st(1'b0, 1'b0, 4'h6, 32'h7000_0001));
        rq[1].push_back(st(1'b1, 1'b0, 4'h6, 32'h7000_0002));
        expQ.push_back(ex(1'b0, 1'b0, 4'h6, 32'h7000_0000));
        drive();
        for (int n = 0; n < 10 && rq[1].size() != 2; n++) tick();
        chk("head accepted", 64'(rq[1].size()), 2);
        rst = 1'b1;
        #3;
        chk("mid-pkt rst ready", 64'(req_ready), 0);
        tick();
        rq[1].delete();
        drive();
        tick();
        rst = 1'b0;
        rq[0].push_back(st(1'b1, 1'b0, 4'h2, 32'h8000_0000));
        rq[3].push_back(st(1'b1, 1'b0, 4'h3, 32'h8000_0003));
        expQ.push_back(ex(1'b1, 1'b0, 4'h2, 32'h8000_0000));
        expQ.push_back(ex(1'b1, 1'b0, 4'h3, 32'h8000_0003));
        drive();
        run("after mid-pkt rst", 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
